// File: rtl/decode_hazard_unit.sv
// ============================================================================
// Module   : decode_hazard_unit
// Purpose  : Decode-stage forwarding / interlock unit with a MUL EX-hold
//            counter. Define HAZARD_FWD_EN for forwarding; the default build
//            is a pure interlock against a write-through register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_hazard_unit #(
   parameter int DATA_W           = 32,
   parameter int ADDR_W           = 5,
   parameter int NUM_STAGES       = 3,
   parameter int LOAD_READY_STAGE = 1,
   parameter int MUL_LAT          = 3
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_id_valid,
   input  logic [ADDR_W-1:0]            i_id_rs_addr,
   input  logic [ADDR_W-1:0]            i_id_rt_addr,
   input  logic                         i_id_rs_used,
   input  logic                         i_id_rt_used,
   input  logic [DATA_W-1:0]            i_id_rs_rf,
   input  logic [DATA_W-1:0]            i_id_rt_rf,
   input  logic [ADDR_W-1:0]            i_id_dest_addr,
   input  logic                         i_id_dest_we,
   input  logic                         i_id_is_load,
   input  logic                         i_id_is_mul,
   input  logic [NUM_STAGES*DATA_W-1:0] i_stage_data,
   output logic [DATA_W-1:0]            o_rs_data,
   output logic [DATA_W-1:0]            o_rt_data,
   output logic                         o_stall,
   output logic                         o_ex_hold
);

   localparam int c_CNT_W = 4;

   logic [NUM_STAGES-1:0] r_valid;
   logic [NUM_STAGES-1:0] r_we;
   logic [NUM_STAGES-1:0] r_load;
   logic [NUM_STAGES-1:0] r_mul;
   logic [ADDR_W-1:0]     r_dest [NUM_STAGES];
   logic [c_CNT_W-1:0]    r_mul_cnt;

   logic                  w_ex_hold;
   logic                  w_issue;
   logic                  w_stall;
   logic                  w_rs_haz;
   logic                  w_rt_haz;
   logic [NUM_STAGES-1:0] w_ready;
   logic [NUM_STAGES-1:0] w_rs_match;
   logic [NUM_STAGES-1:0] w_rt_match;

   assign w_ex_hold = r_valid[0] & r_mul[0] & (r_mul_cnt != '0);

   always_comb begin
      w_ready    = '0;
      w_rs_match = '0;
      w_rt_match = '0;
      for (int k = 0; k < NUM_STAGES; k++) begin
         w_ready[k]    = ~((r_load[k] & (k < LOAD_READY_STAGE)) |
                           (r_mul[k] & (k == 0) & (r_mul_cnt != '0)));
         w_rs_match[k] = r_valid[k] & r_we[k] & (r_dest[k] == i_id_rs_addr) &
                         (i_id_rs_addr != '0);
         w_rt_match[k] = r_valid[k] & r_we[k] & (r_dest[k] == i_id_rt_addr) &
                         (i_id_rt_addr != '0);
      end
   end

`ifdef HAZARD_FWD_EN
   // Returns {hazard, data}; scanning oldest-to-youngest lets the youngest match win.
   function automatic logic [DATA_W:0] f_pick(
      input logic [NUM_STAGES-1:0]        m,
      input logic [NUM_STAGES-1:0]        rdy,
      input logic [NUM_STAGES*DATA_W-1:0] sd,
      input logic [DATA_W-1:0]            rf
   );
      logic              haz;
      logic [DATA_W-1:0] data;
      haz  = 1'b0;
      data = rf;
      for (int k = NUM_STAGES-1; k >= 0; k--) begin
         if (m[k]) begin
            haz  = ~rdy[k];
            data = sd[k*DATA_W +: DATA_W];
         end
      end
      return {haz, data};
   endfunction

   logic [DATA_W:0] w_rs_pick;
   logic [DATA_W:0] w_rt_pick;

   assign w_rs_pick = f_pick(w_rs_match, w_ready, i_stage_data, i_id_rs_rf);
   assign w_rt_pick = f_pick(w_rt_match, w_ready, i_stage_data, i_id_rt_rf);
   assign w_rs_haz  = w_rs_pick[DATA_W];
   assign w_rt_haz  = w_rt_pick[DATA_W];
   assign o_rs_data = w_rs_pick[DATA_W-1:0];
   assign o_rt_data = w_rt_pick[DATA_W-1:0];
`else
   // The write-through register file already covers a WB-stage match.
   logic w_unused_fwd;

   assign w_rs_haz     = |w_rs_match[NUM_STAGES-2:0];
   assign w_rt_haz     = |w_rt_match[NUM_STAGES-2:0];
   assign o_rs_data    = i_id_rs_rf;
   assign o_rt_data    = i_id_rt_rf;
   assign w_unused_fwd = ^{i_stage_data, w_ready,
                           w_rs_match[NUM_STAGES-1], w_rt_match[NUM_STAGES-1]};
`endif

   assign w_stall = i_id_valid & ((i_id_rs_used & w_rs_haz) |
                                  (i_id_rt_used & w_rt_haz) | w_ex_hold);
   assign w_issue = i_id_valid & ~w_stall;

   assign o_stall   = w_stall;
   assign o_ex_hold = w_ex_hold;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid   <= '0;
         r_we      <= '0;
         r_load    <= '0;
         r_mul     <= '0;
         r_mul_cnt <= '0;
         for (int k = 0; k < NUM_STAGES; k++) begin
            r_dest[k] <= '0;
         end
      end else begin
         if (!w_ex_hold) begin
            r_valid[0] <= w_issue;
            r_dest[0]  <= i_id_dest_addr;
            r_we[0]    <= w_issue & i_id_dest_we & (i_id_dest_addr != '0);
            r_load[0]  <= w_issue & i_id_is_load;
            r_mul[0]   <= w_issue & i_id_is_mul;
         end

         // While EX is frozen the held MUL must not also appear downstream.
         r_valid[1] <= r_valid[0] & ~w_ex_hold;
         r_dest[1]  <= r_dest[0];
         r_we[1]    <= r_we[0];
         r_load[1]  <= r_load[0];
         r_mul[1]   <= r_mul[0];

         for (int k = 2; k < NUM_STAGES; k++) begin
            r_valid[k] <= r_valid[k-1];
            r_dest[k]  <= r_dest[k-1];
            r_we[k]    <= r_we[k-1];
            r_load[k]  <= r_load[k-1];
            r_mul[k]   <= r_mul[k-1];
         end

         if (!w_ex_hold && w_issue && i_id_is_mul) begin
            r_mul_cnt <= c_CNT_W'(MUL_LAT - 1);
         end else if (r_mul_cnt != '0) begin
            r_mul_cnt <= r_mul_cnt - 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_decode_hazard_unit.sv
// ============================================================================
// Module   : tb_decode_hazard_unit
// Purpose  : Directed scoreboard bench for decode_hazard_unit (default params).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_hazard_unit;

`ifdef HAZARD_FWD_EN
   localparam bit FWD_EN = 1'b1;
`else
   localparam bit FWD_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [4:0]  rs_addr, rt_addr, dest_addr;
   logic        rs_used, rt_used, dest_we, is_load, is_mul;
   logic [31:0] rs_rf, rt_rf;
   logic [95:0] stage_data;
   logic [31:0] rs_data, rt_data;
   logic        stall, ex_hold;

   always #5 clk = ~clk;

   decode_hazard_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_id_valid     (id_valid),
      .i_id_rs_addr   (rs_addr),
      .i_id_rt_addr   (rt_addr),
      .i_id_rs_used   (rs_used),
      .i_id_rt_used   (rt_used),
      .i_id_rs_rf     (rs_rf),
      .i_id_rt_rf     (rt_rf),
      .i_id_dest_addr (dest_addr),
      .i_id_dest_we   (dest_we),
      .i_id_is_load   (is_load),
      .i_id_is_mul    (is_mul),
      .i_stage_data   (stage_data),
      .o_rs_data      (rs_data),
      .o_rt_data      (rt_data),
      .o_stall        (stall),
      .o_ex_hold      (ex_hold)
   );

   typedef struct {
      string       nm;
      logic        stall;
      logic        hold;
      logic        chk_rs;
      logic [31:0] rs;
      logic        chk_rt;
      logic [31:0] rt;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   n_checks = 0;
   int   n_fail   = 0;

   // Monitor: the DUT presents a combinational answer every cycle.
   always @(negedge clk) begin
      if (q.size() != 0) begin
         e = q.pop_front();
         n_checks++;
         if (stall !== e.stall) begin
            n_fail++;
            $display("FAIL %s stall: got %0b expected %0b", e.nm, stall, e.stall);
         end
         n_checks++;
         if (ex_hold !== e.hold) begin
            n_fail++;
            $display("FAIL %s ex_hold: got %0b expected %0b", e.nm, ex_hold, e.hold);
         end
         if (e.chk_rs) begin
            n_checks++;
            if (rs_data !== e.rs) begin
               n_fail++;
               $display("FAIL %s rs_data: got %h expected %h", e.nm, rs_data, e.rs);
            end
         end
         if (e.chk_rt) begin
            n_checks++;
            if (rt_data !== e.rt) begin
               n_fail++;
               $display("FAIL %s rt_data: got %h expected %h", e.nm, rt_data, e.rt);
            end
         end
      end
   end

   task automatic idle();
      id_valid = 0; rs_addr = 0; rt_addr = 0; rs_used = 0; rt_used = 0;
      rs_rf = 0; rt_rf = 0; dest_addr = 0; dest_we = 0; is_load = 0; is_mul = 0;
   endtask

   task automatic wr(input logic [4:0] d, input logic ld, input logic ml);
      idle();
      id_valid = 1; dest_addr = d; dest_we = 1; is_load = ld; is_mul = ml;
   endtask

   task automatic rd(input logic [4:0] rs, input logic rsu, input logic [31:0] rsv,
                     input logic [4:0] rt, input logic rtu, input logic [31:0] rtv);
      idle();
      id_valid = 1; rs_addr = rs; rs_used = rsu; rs_rf = rsv;
      rt_addr = rt; rt_used = rtu; rt_rf = rtv;
   endtask

   task automatic sd(input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2);
      stage_data = {s2, s1, s0};
   endtask

   task automatic step(input string nm, input logic es, input logic eh,
                       input logic crs, input logic [31:0] ers,
                       input logic crt, input logic [31:0] ert);
      exp_t x;
      x.nm = nm; x.stall = es; x.hold = eh;
      x.chk_rs = crs; x.rs = ers; x.chk_rt = crt; x.rt = ert;
      q.push_back(x);
      @(posedge clk);
      #1;
   endtask

   task automatic stalls(input string nm, input int n, input logic eh);
      for (int i = 0; i < n; i++) step(nm, 1, eh, 0, 0, 0, 0);
   endtask

   task automatic drain();
      idle();
      for (int i = 0; i < 3; i++) step("drain", 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst_n = 0;
      idle();
      sd(0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      rd(3, 1, 32'h55, 0, 0, 0);
      step("reset_state", 0, 0, 1, 32'h55, 0, 0);
      rst_n = 1;
      drain();

      // Forward from EX
      wr(3, 0, 0);
      step("ex_add_issue", 0, 0, 0, 0, 0, 0);
      rd(3, 1, 32'hAAAA, 0, 0, 0);
      sd(32'h11, 0, 0);
      stalls("ex_fwd_stall", FWD_EN ? 0 : 2, 0);
      step("ex_fwd_data", 0, 0, 1, FWD_EN ? 32'h11 : 32'hAAAA, 0, 0);
      drain();

      // Load-use
      wr(5, 1, 0);
      step("lw_issue", 0, 0, 0, 0, 0, 0);
      rd(0, 0, 0, 5, 1, 32'h1234);
      sd(0, 32'hDEAD_BEEF, 0);
      stalls("load_use_stall", FWD_EN ? 1 : 2, 0);
      step("load_use_data", 0, 0, 0, 0, 1, FWD_EN ? 32'hDEAD_BEEF : 32'h1234);
      drain();

      // MUL hold with an independent reader
      wr(7, 0, 1);
      step("mul_issue", 0, 0, 0, 0, 0, 0);
      rd(9, 1, 32'h99, 0, 0, 0);
      stalls("mul_hold", 2, 1);
      step("mul_release", 0, 0, 1, 32'h99, 0, 0);
      drain();

      // MUL hold with a dependent reader
      wr(7, 0, 1);
      step("mul_dep_issue", 0, 0, 0, 0, 0, 0);
      rd(7, 1, 32'h70, 0, 0, 0);
      sd(32'h77, 0, 0);
      stalls("mul_dep_hold", 2, 1);
      stalls("mul_dep_stall", FWD_EN ? 0 : 2, 0);
      step("mul_dep_data", 0, 0, 1, FWD_EN ? 32'h77 : 32'h70, 0, 0);
      drain();

      // Youngest wins: r4 in stage 2 (0x1) and stage 1 (0x2)
      wr(4, 0, 0);
      step("young_w1", 0, 0, 0, 0, 0, 0);
      wr(4, 0, 0);
      step("young_w2", 0, 0, 0, 0, 0, 0);
      idle();
      step("young_gap", 0, 0, 0, 0, 0, 0);
      rd(4, 1, 32'h3333, 0, 0, 0);
      sd(0, 32'h2, 32'h1);
      stalls("young_stall", FWD_EN ? 0 : 1, 0);
      step("young_data", 0, 0, 1, FWD_EN ? 32'h2 : 32'h3333, 0, 0);
      drain();

      // Younger not-ready load shadows an older ready ADD
      wr(4, 0, 0);
      step("young_ld_w1", 0, 0, 0, 0, 0, 0);
      wr(4, 1, 0);
      step("young_ld_w2", 0, 0, 0, 0, 0, 0);
      rd(4, 1, 32'h3333, 0, 0, 0);
      sd(32'h5, 32'h2, 32'h1);
      stalls("young_ld_stall", FWD_EN ? 1 : 2, 0);
      step("young_ld_data", 0, 0, 1, FWD_EN ? 32'h2 : 32'h3333, 0, 0);
      drain();

      // Register 0
      wr(0, 0, 0);
      step("r0_issue", 0, 0, 0, 0, 0, 0);
      rd(0, 1, 0, 0, 1, 0);
      sd(32'hFFFF, 32'hEEEE, 32'hDDDD);
      step("r0_read", 0, 0, 1, 0, 1, 0);
      drain();

      // Unused source never stalls
      wr(6, 0, 0);
      step("unused_issue", 0, 0, 0, 0, 0, 0);
      rd(1, 1, 32'h10, 6, 0, 32'h66);
      step("unused_src", 0, 0, 1, 32'h10, 0, 0);
      drain();

      // Simultaneous rs and rt hazards
      wr(12, 0, 0);
      step("dual_w1", 0, 0, 0, 0, 0, 0);
      wr(13, 1, 0);
      step("dual_w2", 0, 0, 0, 0, 0, 0);
      rd(12, 1, 32'h12, 13, 1, 32'h13);
      sd(32'hA0, 32'hB1, 32'hC2);
      stalls("dual_stall", FWD_EN ? 1 : 2, 0);
      step("dual_data", 0, 0, 1, FWD_EN ? 32'hC2 : 32'h12, 1, FWD_EN ? 32'hB1 : 32'h13);
      drain();

      // Reset mid-MUL
      wr(7, 0, 1);
      step("rst_mul_issue", 0, 0, 0, 0, 0, 0);
      idle();
      rst_n = 0;
      step("rst_mul_before", 0, 1, 0, 0, 0, 0);
      rst_n = 1;
      rd(7, 1, 32'h70, 0, 0, 0);
      sd(32'h77, 32'h77, 32'h77);
      step("rst_mul_after", 0, 0, 1, 32'h70, 0, 0);
      step("rst_mul_after2", 0, 0, 1, 32'h70, 0, 0);
      drain();

      #10;
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_empty: got %0d pending expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
